seg_scan_driver: RTL

Converts a 14-bit binary value to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes those digits onto a shared 4-bit digit bus that feeds the per-digit seven-segment decoder, driving one active-low anode enable per digit. It sits directly upstream of the seven-segment decoder and between the application logic (score/timer values) and the board display.

---
 rtl/seg_scan_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a multiplexed
// four-digit seven-segment scan with optional leading-zero blanking.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    input  logic        load,
    input  logic        blank_lead,
    output logic [3:0]  digit,
    output logic [3:0]  anode,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t        state_q;
    logic [13:0]   bin_q;
    logic [15:0]   bcd_q;
    logic [3:0]    cnt_q;
    logic          sat_q;
    logic          busy_q;
    logic [15:0]   disp_q;
    logic          ovf_q;
    logic [PW-1:0] pre_q;
    logic [1:0]    idx_q;
    logic [3:0]    digit_q;
    logic [3:0]    anode_q;

    logic [29:0]   shift_d;
    logic [3:0]    digit_d;
    logic [3:0]    anode_d;
    logic          blank_d;
    logic          z3_d;
    logic          z2_d;
    logic          z1_d;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

    // One double-dabble step over the combined {bcd, bin} shift register.
    always_comb begin
        shift_d = {bcd_adjust(bcd_q), bin_q} << 1;
    end

    // Conversion FSM: capture/saturate, 14 shift steps, then commit to the display.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= 14'd0;
            bcd_q   <= 16'd0;
            cnt_q   <= 4'd0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            disp_q  <= 16'd0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        if (value > 14'd9999) begin
                            bin_q <= 14'd9999;
                            sat_q <= 1'b1;
                        end else begin
                            bin_q <= value;
                            sat_q <= 1'b0;
                        end
                        bcd_q   <= 16'd0;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {bcd_q, bin_q} <= shift_d;
                    cnt_q          <= cnt_q + 4'd1;
                    if (cnt_q == 4'd13) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    disp_q  <= bcd_q;
                    ovf_q   <= sat_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running refresh prescaler and scan index; independent of conversions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= 2'd0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Leading-zero blanking: a position is dark when it and every higher digit is zero.
    always_comb begin
        z3_d = (disp_q[15:12] == 4'd0);
        z2_d = z3_d && (disp_q[11:8] == 4'd0);
        z1_d = z2_d && (disp_q[7:4] == 4'd0);
        case (idx_q)
            2'd1:    blank_d = blank_lead && z1_d;
            2'd2:    blank_d = blank_lead && z2_d;
            2'd3:    blank_d = blank_lead && z3_d;
            default: blank_d = 1'b0;
        endcase
        digit_d = disp_q[{idx_q, 2'b00} +: 4];
        if (blank_d) begin
            anode_d = 4'b1111;
        end else begin
            anode_d = ~(4'b0001 << idx_q);
        end
    end

    // Registered digit bus and anode enables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
            anode_q <= 4'b1110;
        end else begin
            digit_q <= digit_d;
            anode_q <= anode_d;
        end
    end

    assign digit    = digit_q;
    assign anode    = anode_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule
